tube_dma_ctrl: RTL and testbench

Parasite-side fly-by DMA controller that services the Tube's register-3 DMA handshake. It watches `drq`, acquires the parasite bus, and drives `dack_b`, a memory address and `p_rdnw` for one cycle per byte. Data moves directly between memory and the Tube register 3 FIFO on the shared parasite data bus. Under DMA the Tube inverts the sense of `p_rdnw`, so one cycle serves as both a memory read and a Tube write, or the reverse. The block never touches the data bus.

---
 rtl/tube_dma_pkg.sv | 18 +
 rtl/tube_sync.sv | 24 ++
 rtl/tube_dma_ctrl.sv | 127 ++++++++++++
 tb/tb_tube_dma_ctrl.sv | 268 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/tube_dma_pkg.sv
// Shared types and constants for the Tube register-3 fly-by DMA controller.
package tube_dma_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_WAIT_DRQ,
    ST_REQ,
    ST_XFER,
    ST_HOLD
  } dma_state_t;

  localparam logic DIR_TUBE_TO_MEM = 1'b0;
  localparam logic DIR_MEM_TO_TUBE = 1'b1;

  localparam int unsigned DEF_SYNC_STAGES = 2;
  localparam int unsigned DEF_HOLD_CYCLES = 2;

endpackage

// File: rtl/tube_sync.sv
// N-flop level synchroniser with asynchronous clear.
module tube_sync #(
  parameter int unsigned STAGES = 2
) (
  input  logic p_phi2,
  input  logic p_rst_b,
  input  logic d,
  output logic q
);

  logic [STAGES-1:0] sync_q;

  // Shift the asynchronous input through the flop chain.
  always_ff @(posedge p_phi2 or negedge p_rst_b) begin
    if (!p_rst_b) begin
      sync_q <= '0;
    end else begin
      sync_q <= {sync_q[STAGES-2:0], d};
    end
  end

  assign q = sync_q[STAGES-1];

endmodule

// File: rtl/tube_dma_ctrl.sv
// Parasite-side fly-by DMA controller for the Tube register-3 handshake.
// Drives dack_b, address and p_rdnw for one cycle per byte; never touches data.
module tube_dma_ctrl
  import tube_dma_pkg::*;
#(
  parameter int unsigned SYNC_STAGES = DEF_SYNC_STAGES,
  parameter int unsigned HOLD_CYCLES = DEF_HOLD_CYCLES
) (
  input  logic        p_phi2,
  input  logic        p_rst_b,
  input  logic        drq,
  input  logic        cfg_start,
  input  logic        cfg_dir,
  input  logic [15:0] cfg_addr,
  input  logic [15:0] cfg_len,
  input  logic        abort,
  input  logic        bus_gnt,
  output logic        bus_req,
  output logic        dack_b,
  output logic [15:0] dma_addr,
  output logic        dma_rdnw,
  output logic        dma_oe,
  output logic        busy,
  output logic        done,
  output logic        aborted,
  output logic [15:0] remaining
);

  localparam int unsigned HOLD_W = (HOLD_CYCLES > 2) ? $clog2(HOLD_CYCLES) : 1;

  dma_state_t        state;
  logic [15:0]       addr_q;
  logic [HOLD_W-1:0] hold_cnt;
  logic              drq_s;

  tube_sync #(
    .STAGES (SYNC_STAGES)
  ) u_drq_sync (
    .p_phi2  (p_phi2),
    .p_rst_b (p_rst_b),
    .d       (drq),
    .q       (drq_s)
  );

  // Transfer sequencer: every output is registered and changes only with state.
  always_ff @(posedge p_phi2 or negedge p_rst_b) begin
    if (!p_rst_b) begin
      state     <= ST_IDLE;
      addr_q    <= '0;
      hold_cnt  <= '0;
      bus_req   <= 1'b0;
      dack_b    <= 1'b1;
      dma_oe    <= 1'b0;
      dma_addr  <= '0;
      dma_rdnw  <= DIR_MEM_TO_TUBE;
      busy      <= 1'b0;
      done      <= 1'b0;
      aborted   <= 1'b0;
      remaining <= '0;
    end else if (abort && (state != ST_IDLE)) begin
      // Abort wins over every other transition; remaining is left as-is.
      state   <= ST_IDLE;
      bus_req <= 1'b0;
      dack_b  <= 1'b1;
      dma_oe  <= 1'b0;
      busy    <= 1'b0;
      aborted <= 1'b1;
    end else begin
      case (state)
        ST_IDLE: begin
          if (cfg_start) begin
            addr_q    <= cfg_addr;
            dma_rdnw  <= cfg_dir;
            remaining <= cfg_len;
            aborted   <= 1'b0;
            if (cfg_len == '0) begin
              done <= 1'b1;
            end else begin
              done  <= 1'b0;
              busy  <= 1'b1;
              state <= ST_WAIT_DRQ;
            end
          end
        end
        ST_WAIT_DRQ: begin
          if (drq_s) begin
            bus_req <= 1'b1;
            state   <= ST_REQ;
          end
        end
        ST_REQ: begin
          if (bus_gnt) begin
            dack_b   <= 1'b0;
            dma_oe   <= 1'b1;
            dma_addr <= addr_q;
            state    <= ST_XFER;
          end
        end
        ST_XFER: begin
          dack_b    <= 1'b1;
          dma_oe    <= 1'b0;
          addr_q    <= addr_q + 16'd1;
          remaining <= remaining - 16'd1;
          hold_cnt  <= HOLD_W'(HOLD_CYCLES - 1);
          state     <= ST_HOLD;
        end
        ST_HOLD: begin
          if (hold_cnt != '0) begin
            hold_cnt <= hold_cnt - HOLD_W'(1);
          end else if (remaining == '0) begin
            bus_req <= 1'b0;
            busy    <= 1'b0;
            done    <= 1'b1;
            state   <= ST_IDLE;
          end else if (drq_s) begin
            state <= ST_REQ;
          end else begin
            bus_req <= 1'b0;
            state   <= ST_WAIT_DRQ;
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_tube_dma_ctrl.sv
// Directed self-checking bench for tube_dma_ctrl (default parameters).
module tb_tube_dma_ctrl;

  logic        p_phi2;
  logic        p_rst_b;
  logic        drq;
  logic        cfg_start;
  logic        cfg_dir;
  logic [15:0] cfg_addr;
  logic [15:0] cfg_len;
  logic        abort;
  logic        bus_gnt;
  logic        bus_req;
  logic        dack_b;
  logic [15:0] dma_addr;
  logic        dma_rdnw;
  logic        dma_oe;
  logic        busy;
  logic        done;
  logic        aborted;
  logic [15:0] remaining;

  // 0: manual grant, 1: grant = bus_req one cycle late, 2: grant = bus_req
  int unsigned gnt_mode;
  logic        gnt_man;
  logic        gnt_dly;

  int unsigned n_chk;
  int unsigned n_pass;

  tube_dma_ctrl #(
    .SYNC_STAGES (2),
    .HOLD_CYCLES (2)
  ) dut (
    .p_phi2    (p_phi2),
    .p_rst_b   (p_rst_b),
    .drq       (drq),
    .cfg_start (cfg_start),
    .cfg_dir   (cfg_dir),
    .cfg_addr  (cfg_addr),
    .cfg_len   (cfg_len),
    .abort     (abort),
    .bus_gnt   (bus_gnt),
    .bus_req   (bus_req),
    .dack_b    (dack_b),
    .dma_addr  (dma_addr),
    .dma_rdnw  (dma_rdnw),
    .dma_oe    (dma_oe),
    .busy      (busy),
    .done      (done),
    .aborted   (aborted),
    .remaining (remaining)
  );

  initial p_phi2 = 1'b0;
  always #5 p_phi2 = ~p_phi2;

  always @(posedge p_phi2 or negedge p_rst_b) begin
    if (!p_rst_b) gnt_dly <= 1'b0;
    else          gnt_dly <= bus_req;
  end

  always_comb begin
    bus_gnt = gnt_man;
    case (gnt_mode)
      1:       bus_gnt = gnt_dly;
      2:       bus_gnt = bus_req;
      default: bus_gnt = gnt_man;
    endcase
  end

  task automatic chk(input string tag, input logic [15:0] got, input logic [15:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", tag, got, exp);
  endtask

  task automatic tick();
    @(posedge p_phi2);
    #1;
  endtask

  // Advance until dack_b is low; n is the number of edges taken.
  task automatic wait_dack(input string tag, output int unsigned n);
    n = 0;
    while (dack_b !== 1'b0 && n < 40) begin
      tick();
      n++;
    end
    if (dack_b !== 1'b0) chk({tag, "_timeout"}, 16'(dack_b), 16'd0);
  endtask

  task automatic start(input logic [15:0] a, input logic [15:0] l, input logic d);
    cfg_addr  = a;
    cfg_len   = l;
    cfg_dir   = d;
    cfg_start = 1'b1;
    tick();
    cfg_start = 1'b0;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    int unsigned n;
    logic        bad;

    n_chk = 0; n_pass = 0;
    p_rst_b = 1'b0; drq = 1'b0; cfg_start = 1'b0; cfg_dir = 1'b0;
    cfg_addr = '0; cfg_len = '0; abort = 1'b0;
    gnt_mode = 0; gnt_man = 1'b0;

    // Reset values
    tick(); tick();
    chk("rst_bus_req", 16'(bus_req), 16'd0);
    chk("rst_dack_b", 16'(dack_b), 16'd1);
    chk("rst_dma_oe", 16'(dma_oe), 16'd0);
    chk("rst_dma_addr", dma_addr, 16'h0000);
    chk("rst_dma_rdnw", 16'(dma_rdnw), 16'd1);
    chk("rst_flags", {13'd0, busy, done, aborted}, 16'd0);
    chk("rst_remaining", remaining, 16'd0);
    p_rst_b = 1'b1;

    // Basic transfer: 3 bytes from 0x2000, Tube->memory, grant one cycle late
    gnt_mode = 1;
    drq = 1'b1;
    tick(); tick(); tick();
    start(16'h2000, 16'd3, 1'b0);
    chk("basic_busy", 16'(busy), 16'd1);
    chk("basic_rem0", remaining, 16'd3);
    for (int unsigned b = 0; b < 3; b++) begin
      wait_dack("basic_dack", n);
      chk("basic_gap", 16'(n), 16'd3);
      chk("basic_addr", dma_addr, 16'h2000 + 16'(b));
      chk("basic_rdnw", 16'(dma_rdnw), 16'd0);
      chk("basic_oe", 16'(dma_oe), 16'd1);
      tick();
      chk("basic_dack_width", 16'(dack_b), 16'd1);
    end
    tick(); tick();
    chk("basic_done", 16'(done), 16'd1);
    chk("basic_busy_end", 16'(busy), 16'd0);
    chk("basic_rem_end", remaining, 16'd0);
    chk("basic_req_end", 16'(bus_req), 16'd0);

    // Address wrap, memory->Tube
    start(16'hFFFF, 16'd2, 1'b1);
    chk("wrap_done_clr", 16'(done), 16'd0);
    wait_dack("wrap_dack0", n);
    chk("wrap_addr0", dma_addr, 16'hFFFF);
    chk("wrap_rdnw0", 16'(dma_rdnw), 16'd1);
    tick();
    wait_dack("wrap_dack1", n);
    chk("wrap_addr1", dma_addr, 16'h0000);
    chk("wrap_rdnw1", 16'(dma_rdnw), 16'd1);
    tick(); tick(); tick();
    chk("wrap_done", 16'(done), 16'd1);

    // Bus release: one drq pulse per byte, immediate grant
    gnt_mode = 2;
    drq = 1'b0;
    tick(); tick(); tick();
    start(16'h1000, 16'd2, 1'b0);
    for (int unsigned i = 0; i < 5; i++) tick();
    chk("rel_idle_req", 16'(bus_req), 16'd0);
    chk("rel_idle_busy", 16'(busy), 16'd1);
    for (int unsigned b = 0; b < 2; b++) begin
      drq = 1'b1;
      wait_dack("rel_dack", n);
      chk("rel_latency", 16'(n), 16'd4);
      chk("rel_addr", dma_addr, 16'h1000 + 16'(b));
      drq = 1'b0;
      tick();
      chk("rel_dack_width", 16'(dack_b), 16'd1);
      chk("rel_hold_req", 16'(bus_req), 16'd1);
      tick(); tick();
      chk("rel_req_drop", 16'(bus_req), 16'd0);
      chk("rel_done", 16'(done), 16'(b == 1));
      for (int unsigned i = 0; i < 10; i++) tick();
      chk("rel_gap_req", 16'(bus_req), 16'd0);
    end

    // Grant stall: bus_gnt low for 20 cycles in REQ
    gnt_mode = 0;
    gnt_man = 1'b0;
    drq = 1'b1;
    start(16'h3000, 16'd1, 1'b1);
    n = 0;
    while (bus_req !== 1'b1 && n < 10) begin
      tick();
      n++;
    end
    chk("stall_req", 16'(bus_req), 16'd1);
    bad = 1'b0;
    for (int unsigned i = 0; i < 20; i++) begin
      tick();
      if (dack_b !== 1'b1 || dma_oe !== 1'b0 || bus_req !== 1'b1) bad = 1'b1;
    end
    chk("stall_quiet", 16'(bad), 16'd0);
    gnt_man = 1'b1;
    tick();
    chk("stall_dack", 16'(dack_b), 16'd0);
    chk("stall_oe", 16'(dma_oe), 16'd1);
    chk("stall_addr", dma_addr, 16'h3000);
    tick();
    chk("stall_dack_end", 16'(dack_b), 16'd1);
    tick(); tick();
    chk("stall_done", 16'(done), 16'd1);
    gnt_man = 1'b0;

    // Abort in HOLD after byte 1 of 4; a start pulse while busy is ignored
    gnt_mode = 2;
    start(16'h4000, 16'd4, 1'b0);
    wait_dack("abort_dack", n);
    chk("abort_addr", dma_addr, 16'h4000);
    cfg_len = 16'd0;
    cfg_start = 1'b1;
    tick();
    cfg_start = 1'b0;
    chk("abort_busy_hold", 16'(busy), 16'd1);
    chk("abort_rem_hold", remaining, 16'd3);
    chk("abort_start_ign", 16'(done), 16'd0);
    abort = 1'b1;
    tick();
    abort = 1'b0;
    chk("abort_flag", 16'(aborted), 16'd1);
    chk("abort_req", 16'(bus_req), 16'd0);
    chk("abort_busy", 16'(busy), 16'd0);
    chk("abort_rem", remaining, 16'd3);
    chk("abort_dack", {14'd0, dack_b, dma_oe}, 16'b10);
    tick();
    chk("abort_stay", 16'(bus_req), 16'd0);

    // Zero length completes at once
    start(16'h5000, 16'd0, 1'b0);
    chk("zero_done", 16'(done), 16'd1);
    chk("zero_abort_clr", 16'(aborted), 16'd0);
    chk("zero_busy", 16'(busy), 16'd0);
    tick(); tick(); tick();
    chk("zero_no_req", 16'(bus_req), 16'd0);

    // Reset during XFER
    start(16'h6000, 16'd2, 1'b0);
    wait_dack("rstx_dack", n);
    chk("rstx_in_xfer", 16'(dack_b), 16'd0);
    #2;
    p_rst_b = 1'b0;
    #1;
    chk("rstx_dack_b", 16'(dack_b), 16'd1);
    chk("rstx_oe", 16'(dma_oe), 16'd0);
    chk("rstx_req", 16'(bus_req), 16'd0);
    chk("rstx_flags", {13'd0, busy, done, aborted}, 16'd0);
    chk("rstx_rem", remaining, 16'd0);
    chk("rstx_addr", dma_addr, 16'h0000);
    chk("rstx_rdnw", 16'(dma_rdnw), 16'd1);
    tick();
    p_rst_b = 1'b1;
    tick();

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
